// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module  : cpu_pkg
//  Brief   : Shared CPU constants and helpers for the ID-stage scoreboard.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam logic [AW-1:0] REG_ZERO = '0;

    // Bits needed to hold a per-register pending count of 0..max_pend.
    function automatic int pend_cnt_w(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_pend_ctr.sv
// ============================================================================
//  Module  : sb_pend_ctr
//  Brief   : Saturating up/down pending-write counter for one register.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_pend_ctr #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         nz
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Simultaneous inc and dec cancel; both ends saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign nz  = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/id_scoreboard.sv
// ============================================================================
//  Module  : id_scoreboard
//  Brief   : ID-stage register scoreboard tracking in-flight long-latency writes.
//            Optional macro SB_PERF_CNT_EN adds a saturating stall_cycles counter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG         = cpu_pkg::NREG,
    parameter int AW           = cpu_pkg::AW,
    parameter int MAX_PEND     = 3,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [AW-1:0]                     rs1Addr_id,
    input  logic [AW-1:0]                     rs2Addr_id,
    input  logic                              rs1_used,
    input  logic                              rs2_used,
    input  logic                              issue_valid,
    input  logic [AW-1:0]                     issue_rd,
    input  logic                              wb_valid,
    input  logic [AW-1:0]                     wb_rd,
    input  logic                              flush,
    output logic                              Stall,
    output logic                              IFWrite,
    output logic [NREG-1:0]                   busy_vec,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt
`ifdef SB_PERF_CNT_EN
    ,
    output logic [31:0]                       stall_cycles
`endif
);

    localparam int PW = pend_cnt_w(MAX_PEND);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    logic [PW-1:0] pend_cnt [NREG];
    logic [IW-1:0] inflight_q;
    logic [IW-1:0] inflight_d;
    logic          stall_src;
    logic          stall_cap;
    logic          issue_trk;
    logic          retire;

    // Stall depends only on registered state, so retirement frees a source next cycle.
    always_comb begin
        stall_src = (rs1_used && busy_vec[rs1Addr_id]) ||
                    (rs2_used && busy_vec[rs2Addr_id]);
        stall_cap = issue_valid &&
                    ((inflight_q == IW'(MAX_INFLIGHT)) ||
                     (pend_cnt[issue_rd] == PW'(MAX_PEND)));
        Stall     = stall_src || stall_cap;
        IFWrite   = !Stall;
    end

    always_comb begin
        issue_trk = issue_valid && !Stall && (issue_rd != AW'(REG_ZERO));
        retire    = wb_valid && (wb_rd != AW'(REG_ZERO)) && busy_vec[wb_rd];
    end

    assign pend_cnt[0] = '0;
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_pend
        sb_pend_ctr #(
            .MAX (MAX_PEND),
            .W   (PW)
        ) u_ctr (
            .clk (clk),
            .rst (rst),
            .inc (issue_trk && (issue_rd == AW'(r))),
            .dec (retire && (wb_rd == AW'(r))),
            .clr (flush),
            .cnt (pend_cnt[r]),
            .nz  (busy_vec[r])
        );
    end

    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (issue_trk && !retire) begin
            inflight_d = inflight_q + IW'(1);
        end else if (retire && !issue_trk) begin
            inflight_d = inflight_q - IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight_cnt = inflight_q;

`ifdef SB_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (Stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_scoreboard.sv
// ============================================================================
//  Module  : tb_id_scoreboard
//  Brief   : Scoreboard-style directed bench for id_scoreboard.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1Addr_id = '0;
    logic [4:0]  rs2Addr_id = '0;
    logic        rs1_used = 1'b0;
    logic        rs2_used = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic        Stall;
    logic        IFWrite;
    logic [31:0] busy_vec;
    logic [3:0]  inflight_cnt;
`ifdef SB_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    id_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .rs1Addr_id   (rs1Addr_id),
        .rs2Addr_id   (rs2Addr_id),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .Stall        (Stall),
        .IFWrite      (IFWrite),
        .busy_vec     (busy_vec),
        .inflight_cnt (inflight_cnt)
`ifdef SB_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] busy;
        logic [3:0]  infl;
        int          perf;   // -1: do not check
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (Stall !== e.stall || IFWrite !== !e.stall ||
                busy_vec !== e.busy || inflight_cnt !== e.infl) begin
                fails++;
                $display("FAIL %s: got Stall=%0b IFWrite=%0b busy=%h infl=%0d, want Stall=%0b IFWrite=%0b busy=%h infl=%0d",
                         e.name, Stall, IFWrite, busy_vec, inflight_cnt,
                         e.stall, !e.stall, e.busy, e.infl);
            end
`ifdef SB_PERF_CNT_EN
            if (e.perf >= 0) begin
                tests++;
                if (stall_cycles !== 32'(e.perf)) begin
                    fails++;
                    $display("FAIL %s perf: got stall_cycles=%0d, want %0d",
                             e.name, stall_cycles, e.perf);
                end
            end
`endif
        end
    end

    task automatic drive(input string nm, input logic r,
                         input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2,
                         input logic iv, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd,
                         input logic fl,
                         input logic es, input logic [31:0] eb,
                         input logic [3:0] ei, input int ep);
        exp_t e;
        rst = r;
        rs1Addr_id = a1; rs1_used = u1;
        rs2Addr_id = a2; rs2_used = u2;
        issue_valid = iv; issue_rd = ird;
        wb_valid = wv; wb_rd = wrd;
        flush = fl;
        e.name = nm; e.stall = es; e.busy = eb; e.infl = ei; e.perf = ep;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        //        name          rst a1 u1 a2 u2 iv rd wv wrd fl  stall busy          infl perf
        drive("reset_hold",     1, 5'd5, 1, 0, 0, 1, 5'd5, 0, 0, 0,  0, 32'h0,        0,  0);
        drive("idle_after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 32'h0,        0,  0);
        // Load-use on r5 with retirement taking effect one cycle later
        drive("issue5",         0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0,     0, 32'h0,        0, -1);
        drive("use5_wb5",       0, 5'd5, 1, 0, 0, 0, 0, 1, 5'd5, 0,  1, 32'h20,       1, -1);
        drive("use5_after_wb",  0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0,     0, 32'h0,        0, -1);
        // Per-register capacity on r7
        drive("issue7_a",       0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0,     0, 32'h0,        0, -1);
        drive("issue7_b",       0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0,     0, 32'h80,       1, -1);
        drive("issue7_c",       0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0,     0, 32'h80,       2, -1);
        drive("issue7_full",    0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0,     1, 32'h80,       3, -1);
        // Total capacity: five more distinct writers reach eight
        drive("issue10",        0, 0, 0, 0, 0, 1, 5'd10, 0, 0, 0,    0, 32'h80,       3, -1);
        drive("issue11",        0, 0, 0, 0, 0, 1, 5'd11, 0, 0, 0,    0, 32'h480,      4, -1);
        drive("issue12",        0, 0, 0, 0, 0, 1, 5'd12, 0, 0, 0,    0, 32'hC80,      5, -1);
        drive("issue13",        0, 0, 0, 0, 0, 1, 5'd13, 0, 0, 0,    0, 32'h1C80,     6, -1);
        drive("issue14",        0, 0, 0, 0, 0, 1, 5'd14, 0, 0, 0,    0, 32'h3C80,     7, -1);
        drive("issue15_full",   0, 0, 0, 0, 0, 1, 5'd15, 0, 0, 0,    1, 32'h7C80,     8, -1);
        drive("inflight_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 32'h7C80,     8, -1);
        // Asynchronous reset mid-run with writes pending
        drive("midrun_rst_a",   1, 5'd7, 1, 5'd10, 1, 1, 5'd15, 1, 5'd7, 0, 0, 32'h0, 0,  0);
        drive("midrun_rst_b",   1, 5'd7, 1, 5'd10, 1, 1, 5'd15, 0, 0, 0,  0, 32'h0,   0,  0);
        drive("after_midrst",   0, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0,     0, 32'h0,        0,  0);
        // Same-register issue+retire, and retire to an idle register
        drive("issue4",         0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0,     0, 32'h0,        0, -1);
        drive("iss4_wb4",       0, 0, 0, 0, 0, 1, 5'd4, 1, 5'd4, 0,  0, 32'h10,       1, -1);
        drive("iss6_wb9_idle",  0, 0, 0, 0, 0, 1, 5'd6, 1, 5'd9, 0,  0, 32'h10,       1, -1);
        drive("no_wrap_chk",    0, 5'd9, 1, 0, 0, 0, 0, 0, 0, 0,     0, 32'h50,       2, -1);
        drive("iss8_wb4",       0, 0, 0, 0, 0, 1, 5'd8, 1, 5'd4, 0,  0, 32'h50,       2, -1);
        drive("diff_reg_chk",   0, 5'd4, 1, 0, 0, 0, 0, 0, 0, 0,     0, 32'h140,      2, -1);
        // Register zero is never tracked
        drive("iss0_use0",      0, 0, 1, 0, 1, 1, 5'd0, 0, 0, 0,     0, 32'h140,      2, -1);
        drive("r0_untracked",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0,        0, 32'h140,      2, -1);
        // Flush overrides a same-cycle issue; stall computed from old state
        drive("flush_iss3",     0, 5'd6, 1, 0, 0, 1, 5'd3, 1, 5'd8, 1, 1, 32'h140,   2, -1);
        drive("after_flush",    0, 5'd6, 1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 32'h0,       0,  1);
        drive("issue2",         0, 0, 0, 0, 0, 1, 5'd2, 0, 0, 0,     0, 32'h0,        0,  1);
        drive("use2_a",         0, 0, 0, 5'd2, 1, 0, 0, 0, 0, 0,     1, 32'h4,        1,  1);
        drive("use2_b",         0, 0, 0, 5'd2, 1, 0, 0, 0, 0, 0,     1, 32'h4,        1,  2);
        drive("use2_wb2",       0, 0, 0, 5'd2, 1, 0, 0, 1, 5'd2, 0,  1, 32'h4,        1,  3);
        drive("perf_final",     0, 0, 0, 5'd2, 1, 0, 0, 0, 0, 0,     0, 32'h0,        0,  4);

        drive("tail_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 32'h0,        0,  4);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
